// File: rtl/multicycle_datapath_if.sv
// Memory bus between the multicycle core (master) and its memory (slave).
// One transaction completes in any cycle where mem_req and mem_ready are both high.
interface multicycle_datapath_if #(
    parameter int XLEN = 64
);
    logic            mem_req;
    logic            mem_we;
    logic [31:0]     mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_ready;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/multicycle_datapath.sv
// Multicycle RV-subset core: FETCH/DECODE/EXEC/MEM/WB over a single shared memory bus.
// Supports add/sub/and/or, addi, beq and XLEN-sized load/store; anything else halts the core.
module multicycle_datapath #(
    parameter int          XLEN     = 64,
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic                  clock,
    input  logic                  Reset,
    multicycle_datapath_if.master mem,
    output logic [31:0]           Prx_PC,
    output logic [31:0]           Instruction,
    output logic [XLEN-1:0]       ALUResult,
    output logic                  halt
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [2:0] F3_MEM = (XLEN == 64) ? 3'b011 : 3'b010;

    state_t          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] alu_q, alu_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [XLEN-1:0] mdr_q, mdr_d;
    logic [XLEN-1:0] regs_q [32];

    logic            rf_we;
    logic [XLEN-1:0] rf_wdata;
    logic            req_c, we_c;
    logic [31:0]     addr_c;
    logic [XLEN-1:0] wdata_c;

    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [4:0]      rs1, rs2, rd;
    logic            legal;
    logic [31:0]     imm32;
    logic [XLEN-1:0] alu_out, rdata1, rdata2;

    assign opcode = instr_q[6:0];
    assign rd     = instr_q[11:7];
    assign funct3 = instr_q[14:12];
    assign rs1    = instr_q[19:15];
    assign rs2    = instr_q[24:20];
    assign funct7 = instr_q[31:25];

    assign rdata1 = (rs1 == 5'd0) ? '0 : regs_q[rs1];
    assign rdata2 = (rs2 == 5'd0) ? '0 : regs_q[rs2];

    always_comb begin
        legal = 1'b0;
        imm32 = {{20{instr_q[31]}}, instr_q[31:20]};
        case (opcode)
            OP_R: begin
                legal = ((funct3 == 3'b000) && ((funct7 == 7'b0000000) || (funct7 == 7'b0100000)))
                     || (((funct3 == 3'b111) || (funct3 == 3'b110)) && (funct7 == 7'b0000000));
            end
            OP_IMM: legal = (funct3 == 3'b000);
            OP_BR: begin
                legal = (funct3 == 3'b000);
                imm32 = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
            end
            OP_LD: legal = (funct3 == F3_MEM);
            OP_ST: begin
                legal = (funct3 == F3_MEM);
                imm32 = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
            end
            default: legal = 1'b0;
        endcase
    end

    // Address calculation for addi/load/store shares the default add-immediate path.
    always_comb begin
        alu_out = a_q + imm_q;
        case (opcode)
            OP_R: begin
                case (funct3)
                    3'b111:  alu_out = a_q & b_q;
                    3'b110:  alu_out = a_q | b_q;
                    default: alu_out = funct7[5] ? (a_q - b_q) : (a_q + b_q);
                endcase
            end
            OP_BR:   alu_out = a_q - b_q;
            default: alu_out = a_q + imm_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        alu_d    = alu_q;
        a_d      = a_q;
        b_d      = b_q;
        imm_d    = imm_q;
        mdr_d    = mdr_q;
        rf_we    = 1'b0;
        rf_wdata = (opcode == OP_LD) ? mdr_q : alu_q;
        req_c    = 1'b0;
        we_c     = 1'b0;
        addr_c   = '0;
        wdata_c  = '0;
        case (state_q)
            FETCH: begin
                req_c  = 1'b1;
                addr_c = pc_q;
                if (mem.mem_ready) begin
                    instr_d = mem.mem_rdata[31:0];
                    state_d = DECODE;
                end
            end
            DECODE: begin
                a_d     = rdata1;
                b_d     = rdata2;
                imm_d   = XLEN'($signed(imm32));
                state_d = legal ? EXEC : HALT;
            end
            EXEC: begin
                alu_d = alu_out;
                case (opcode)
                    OP_LD, OP_ST: state_d = MEM;
                    OP_BR: begin
                        pc_d    = (a_q == b_q) ? (pc_q + imm_q[31:0]) : (pc_q + 32'd4);
                        state_d = FETCH;
                    end
                    default: state_d = WB;
                endcase
            end
            MEM: begin
                req_c   = 1'b1;
                we_c    = (opcode == OP_ST);
                addr_c  = alu_q[31:0];
                wdata_c = (opcode == OP_ST) ? b_q : '0;
                if (mem.mem_ready) begin
                    if (opcode == OP_ST) begin
                        pc_d    = pc_q + 32'd4;
                        state_d = FETCH;
                    end else begin
                        mdr_d   = mem.mem_rdata;
                        state_d = WB;
                    end
                end
            end
            WB: begin
                rf_we   = (rd != 5'd0);
                pc_d    = pc_q + 32'd4;
                state_d = FETCH;
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // Bus outputs are forced quiet while reset is asserted, whatever the stale state says.
    assign mem.mem_req   = Reset & req_c;
    assign mem.mem_we    = Reset & req_c & we_c;
    assign mem.mem_addr  = Reset ? addr_c : '0;
    assign mem.mem_wdata = Reset ? wdata_c : '0;

    always_ff @(posedge clock) begin
        if (!Reset) begin
            state_q <= FETCH;
            pc_q    <= PC_RESET;
            instr_q <= '0;
            alu_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            mdr_q   <= '0;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            alu_q   <= alu_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            mdr_q   <= mdr_d;
            if (rf_we) begin
                regs_q[rd] <= rf_wdata;
            end
        end
    end

    assign Prx_PC      = pc_q;
    assign Instruction = instr_q;
    assign ALUResult   = alu_q;
    assign halt        = (state_q == HALT);
endmodule

// File: tb/tb_multicycle_datapath.sv
// Self-checking bench for multicycle_datapath: the bench plays memory, queues the expected
// bus transactions and ALU results, and compares them as the core produces them.
module tb_multicycle_datapath;
    localparam int          XLEN     = 64;
    localparam logic [31:0] PC_RESET = 32'h0000_0000;

    logic            clock = 1'b0;
    logic            Reset;
    logic [31:0]     Prx_PC;
    logic [31:0]     Instruction;
    logic [XLEN-1:0] ALUResult;
    logic            halt;

    multicycle_datapath_if #(.XLEN(XLEN)) bus ();

    multicycle_datapath #(.XLEN(XLEN), .PC_RESET(PC_RESET)) dut (
        .clock       (clock),
        .Reset       (Reset),
        .mem         (bus),
        .Prx_PC      (Prx_PC),
        .Instruction (Instruction),
        .ALUResult   (ALUResult),
        .halt        (halt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic            we;
        logic [31:0]     addr;
        logic [XLEN-1:0] wdata;
    } memTx_t;

    memTx_t          expQ [$];
    logic [XLEN-1:0] aluQ [$];
    int              total = 0;
    int              bad = 0;
    int              cycleCount = 0;
    logic [31:0]     expPc;

    function automatic memTx_t mkTx(input logic we, input logic [31:0] addr, input logic [XLEN-1:0] wdata);
        memTx_t t;
        t.we    = we;
        t.addr  = addr;
        t.wdata = wdata;
        return t;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
        cycleCount++;
    endtask

    task automatic waitReq(output bit ok);
        int n = 0;
        while (bus.mem_req !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        ok = (bus.mem_req === 1'b1);
    endtask

    // Waits for a request, holds mem_ready low for 'waits' cycles, then completes it with rdata.
    task automatic serve(input logic [XLEN-1:0] rdata, input int waits, output memTx_t got,
                         output int reqCycle, output bit ok, output bit stable);
        waitReq(ok);
        reqCycle  = cycleCount;
        got.we    = bus.mem_we;
        got.addr  = bus.mem_addr;
        got.wdata = bus.mem_wdata;
        stable    = 1'b1;
        for (int i = 0; i < waits; i++) begin
            tick();
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== got.addr || bus.mem_we !== got.we) stable = 1'b0;
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rdata;
        tick();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = '1;
        tick();
        total++; if ({bus.mem_req, bus.mem_we} !== 2'b00) begin bad++; $display("[TB] FAIL rst_req: req/we=%b want 00", {bus.mem_req, bus.mem_we}); end
        total++; if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== '0) begin bad++; $display("[TB] FAIL rst_bus: addr=%h wdata=%h want 0", bus.mem_addr, bus.mem_wdata); end
        tick();
        total++; if (Prx_PC !== PC_RESET) begin bad++; $display("[TB] FAIL rst_pc: got %h want %h", Prx_PC, PC_RESET); end
        total++; if (halt !== 1'b0) begin bad++; $display("[TB] FAIL rst_halt: got %b want 0", halt); end
        total++; if (Instruction !== 32'h0 || ALUResult !== '0) begin bad++; $display("[TB] FAIL rst_regs: instr=%h alu=%h want 0", Instruction, ALUResult); end
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("[TB] FAIL rst_req2: got %b want 0", bus.mem_req); end
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        Reset = 1'b1;
        #1;
        total++; if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, PC_RESET}) begin bad++; $display("[TB] FAIL rst_first_fetch: req=%b we=%b addr=%h want 1 0 %h", bus.mem_req, bus.mem_we, bus.mem_addr, PC_RESET); end
        expPc = PC_RESET;
    endtask

    task automatic test_alu_seq();
        logic [31:0] prog [2] = '{32'h0050_0093, 32'h0010_8133};
        memTx_t got, exp;
        int c0, c;
        bit ok, st;
        for (int i = 0; i < 2; i++) begin
            expQ.push_back(mkTx(1'b0, expPc, '0));
            serve(XLEN'(prog[i]), 0, got, c, ok, st);
            if (i == 0) c0 = c;
            exp = expQ.pop_front();
            total++; if (!ok || got.we !== exp.we || got.addr !== exp.addr) begin bad++; $display("[TB] FAIL seq_fetch%0d: addr=%h we=%b want %h 0", i, got.addr, got.we, exp.addr); end
            expPc += 32'd4;
        end
        waitReq(ok);
        total++; if (!ok || cycleCount - c0 !== 8) begin bad++; $display("[TB] FAIL seq_cycles: got %0d want 8", cycleCount - c0); end
        total++; if (Prx_PC !== expPc) begin bad++; $display("[TB] FAIL seq_pc: got %h want %h", Prx_PC, expPc); end
        total++; if (ALUResult !== 64'd10) begin bad++; $display("[TB] FAIL seq_alu: got %0d want 10", ALUResult); end
    endtask

    task automatic test_fetch_wait();
        memTx_t got, exp;
        int c0;
        bit ok, st;
        expQ.push_back(mkTx(1'b0, expPc, '0));
        serve(XLEN'(32'h0050_0093), 3, got, c0, ok, st);
        exp = expQ.pop_front();
        total++; if (!ok || got.we !== exp.we || got.addr !== exp.addr) begin bad++; $display("[TB] FAIL wait_fetch: addr=%h we=%b want %h 0", got.addr, got.we, exp.addr); end
        total++; if (st !== 1'b1) begin bad++; $display("[TB] FAIL wait_stable: got %b want 1", st); end
        waitReq(ok);
        expPc += 32'd4;
        total++; if (!ok || cycleCount - c0 !== 7) begin bad++; $display("[TB] FAIL wait_cycles: got %0d want 7", cycleCount - c0); end
        total++; if (Prx_PC !== expPc || ALUResult !== 64'd5) begin bad++; $display("[TB] FAIL wait_result: pc=%h alu=%0d want %h 5", Prx_PC, ALUResult, expPc); end
    endtask

    task automatic test_load_store();
        logic [31:0]     ins [3] = '{32'h0020_3823, 32'h0100_3183, 32'h0030_3C23};
        logic            we  [3] = '{1'b1, 1'b0, 1'b1};
        logic [31:0]     ad  [3] = '{32'd16, 32'd16, 32'd24};
        logic [XLEN-1:0] wd  [3] = '{64'd10, 64'd0, 64'd10};
        logic [XLEN-1:0] rdv [3] = '{64'd0, 64'd10, 64'd0};
        int              cyc [3] = '{4, 5, 4};
        memTx_t got, exp;
        int c0, c1;
        bit ok, st;
        for (int i = 0; i < 3; i++) begin
            expQ.push_back(mkTx(1'b0, expPc, '0));
            serve(XLEN'(ins[i]), 0, got, c0, ok, st);
            exp = expQ.pop_front();
            total++; if (!ok || got.we !== exp.we || got.addr !== exp.addr) begin bad++; $display("[TB] FAIL ls_fetch%0d: addr=%h we=%b want %h 0", i, got.addr, got.we, exp.addr); end
            expQ.push_back(mkTx(we[i], ad[i], wd[i]));
            serve(rdv[i], 0, got, c1, ok, st);
            exp = expQ.pop_front();
            total++; if (!ok || got.we !== exp.we || got.addr !== exp.addr || (exp.we && got.wdata !== exp.wdata)) begin bad++; $display("[TB] FAIL ls_mem%0d: we=%b addr=%h wdata=%0d want %b %h %0d", i, got.we, got.addr, got.wdata, exp.we, exp.addr, exp.wdata); end
            waitReq(ok);
            expPc += 32'd4;
            total++; if (!ok || cycleCount - c0 !== cyc[i]) begin bad++; $display("[TB] FAIL ls_cycles%0d: got %0d want %0d", i, cycleCount - c0, cyc[i]); end
            total++; if (Prx_PC !== expPc) begin bad++; $display("[TB] FAIL ls_pc%0d: got %h want %h", i, Prx_PC, expPc); end
        end
    endtask

    task automatic test_branch();
        memTx_t got, exp;
        int c0, c1;
        bit ok, st;
        // beq x0,x0,-8 at 0x18 is taken back to 0x10.
        expQ.push_back(mkTx(1'b0, expPc, '0));
        serve(XLEN'(32'hFE00_0CE3), 0, got, c0, ok, st);
        exp = expQ.pop_front();
        total++; if (!ok || got.addr !== exp.addr || got.we !== exp.we) begin bad++; $display("[TB] FAIL br_fetch: addr=%h want %h", got.addr, exp.addr); end
        waitReq(ok);
        expPc = expPc - 32'd8;
        total++; if (!ok || cycleCount - c0 !== 3) begin bad++; $display("[TB] FAIL br_cycles: got %0d want 3", cycleCount - c0); end
        total++; if (Prx_PC !== expPc) begin bad++; $display("[TB] FAIL br_taken_pc: got %h want %h", Prx_PC, expPc); end
        // addi x0,x0,7 must not change x0; sd x0 exposes it on the bus.
        serve(XLEN'(32'h0070_0013), 0, got, c0, ok, st);
        waitReq(ok);
        expPc += 32'd4;
        total++; if (ALUResult !== 64'd7 || Prx_PC !== expPc) begin bad++; $display("[TB] FAIL x0_addi: alu=%0d pc=%h want 7 %h", ALUResult, Prx_PC, expPc); end
        serve(XLEN'(32'h0200_3023), 0, got, c0, ok, st);
        expQ.push_back(mkTx(1'b1, 32'd32, '0));
        serve('0, 0, got, c1, ok, st);
        exp = expQ.pop_front();
        total++; if (!ok || got.we !== exp.we || got.addr !== exp.addr || got.wdata !== exp.wdata) begin bad++; $display("[TB] FAIL x0_zero: we=%b addr=%h wdata=%h want 1 %h 0", got.we, got.addr, got.wdata, exp.addr); end
        waitReq(ok);
        expPc += 32'd4;
        // beq x1,x0,-8 with x1=5 falls through.
        serve(XLEN'(32'hFE00_8CE3), 0, got, c0, ok, st);
        waitReq(ok);
        expPc += 32'd4;
        total++; if (!ok || cycleCount - c0 !== 3 || Prx_PC !== expPc) begin bad++; $display("[TB] FAIL br_not_taken: cycles=%0d pc=%h want 3 %h", cycleCount - c0, Prx_PC, expPc); end
    endtask

    task automatic test_back_to_back();
        logic [31:0]     prog [5] = '{32'hFFD0_0293, 32'h4050_8333, 32'h0051_73B3, 32'h0051_6433, 32'h0084_04B3};
        logic [XLEN-1:0] res  [5] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'd8, 64'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE};
        logic [XLEN-1:0] expAlu;
        memTx_t got, exp;
        int c0;
        bit ok, st;
        for (int i = 0; i < 5; i++) begin
            expQ.push_back(mkTx(1'b0, expPc, '0));
            aluQ.push_back(res[i]);
            serve(XLEN'(prog[i]), 0, got, c0, ok, st);
            exp = expQ.pop_front();
            total++; if (!ok || got.addr !== exp.addr || got.we !== exp.we) begin bad++; $display("[TB] FAIL b2b_fetch%0d: addr=%h want %h", i, got.addr, exp.addr); end
            waitReq(ok);
            expPc += 32'd4;
            expAlu = aluQ.pop_front();
            total++; if (!ok || ALUResult !== expAlu) begin bad++; $display("[TB] FAIL b2b_alu%0d: got %h want %h", i, ALUResult, expAlu); end
            total++; if (cycleCount - c0 !== 4 || Prx_PC !== expPc) begin bad++; $display("[TB] FAIL b2b_timing%0d: cycles=%0d pc=%h want 4 %h", i, cycleCount - c0, Prx_PC, expPc); end
        end
    endtask

    task automatic test_halt();
        memTx_t got;
        int c0, reqSeen, haltLow;
        bit ok, st;
        logic [31:0] haltPc;
        haltPc = expPc;
        serve(XLEN'(32'hFFFF_FFFF), 0, got, c0, ok, st);
        total++; if (!ok || got.addr !== haltPc) begin bad++; $display("[TB] FAIL halt_fetch: addr=%h want %h", got.addr, haltPc); end
        tick();
        reqSeen = 0;
        haltLow = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.mem_req !== 1'b0) reqSeen++;
            if (halt !== 1'b1) haltLow++;
            tick();
        end
        total++; if (haltLow !== 0) begin bad++; $display("[TB] FAIL halt_flag: cycles without halt=%0d want 0", haltLow); end
        total++; if (reqSeen !== 0) begin bad++; $display("[TB] FAIL halt_req: cycles with req=%0d want 0", reqSeen); end
        total++; if (Prx_PC !== haltPc) begin bad++; $display("[TB] FAIL halt_pc: got %h want %h", Prx_PC, haltPc); end
        Reset = 1'b0;
        tick();
        total++; if (halt !== 1'b0 || Prx_PC !== PC_RESET) begin bad++; $display("[TB] FAIL halt_reset: halt=%b pc=%h want 0 %h", halt, Prx_PC, PC_RESET); end
        Reset = 1'b1;
        #1;
        total++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, PC_RESET}) begin bad++; $display("[TB] FAIL halt_restart: req=%b addr=%h want 1 %h", bus.mem_req, bus.mem_addr, PC_RESET); end
        expPc = PC_RESET;
    endtask

    task automatic test_illegal_width();
        memTx_t got;
        int c0;
        bit ok, st;
        // lw-style funct3 010 is illegal for XLEN=64.
        serve(XLEN'(32'h0100_2183), 0, got, c0, ok, st);
        tick();
        total++; if (halt !== 1'b1 || bus.mem_req !== 1'b0) begin bad++; $display("[TB] FAIL illegal_lw: halt=%b req=%b want 1 0", halt, bus.mem_req); end
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        #1;
        expPc = PC_RESET;
    endtask

    task automatic test_reset_mid();
        memTx_t got;
        int c0;
        bit ok, st;
        serve(XLEN'(32'h0100_3183), 0, got, c0, ok, st);
        waitReq(ok);
        total++; if (!ok || bus.mem_addr !== 32'd16 || bus.mem_we !== 1'b0) begin bad++; $display("[TB] FAIL mid_memreq: addr=%h we=%b want 10 0", bus.mem_addr, bus.mem_we); end
        Reset = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 64'h55;
        tick();
        total++; if (bus.mem_req !== 1'b0 || Instruction !== 32'h0) begin bad++; $display("[TB] FAIL mid_reset: req=%b instr=%h want 0 0", bus.mem_req, Instruction); end
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        Reset = 1'b1;
        #1;
        total++; if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, PC_RESET}) begin bad++; $display("[TB] FAIL mid_restart: req=%b we=%b addr=%h want 1 0 %h", bus.mem_req, bus.mem_we, bus.mem_addr, PC_RESET); end
        serve(XLEN'(32'h0050_0093), 0, got, c0, ok, st);
        waitReq(ok);
        total++; if (!ok || ALUResult !== 64'd5 || Prx_PC !== PC_RESET + 32'd4) begin bad++; $display("[TB] FAIL mid_resume: alu=%0d pc=%h want 5 %h", ALUResult, Prx_PC, PC_RESET + 32'd4); end
    endtask

    initial begin
        test_reset();
        test_alu_seq();
        test_fetch_wait();
        test_load_store();
        test_branch();
        test_back_to_back();
        test_halt();
        test_illegal_width();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/multicycle_datapath.md
MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

Interface
REQ-001 Parameter XLEN, default 64, data/register width; legal values 32 and 64.
REQ-002 Parameter PC_RESET, default 32'h0000_0000, PC value after reset.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-low reset.
REQ-005 mem_req  output  1  memory transaction request.
REQ-006 mem_we  output  1  1 = write, 0 = read.
REQ-007 mem_addr  output  32  byte address.
REQ-008 mem_wdata  output  XLEN  store data.
REQ-009 mem_ready  input  1  transaction completes in any cycle where mem_req and mem_ready are both 1.
REQ-010 mem_rdata  input  XLEN  read data, valid when mem_ready=1; fetch uses bits [31:0].
REQ-011 Prx_PC  output  32  current PC.
REQ-012 Instruction  output  32  latched instruction register.
REQ-013 ALUResult  output  XLEN  registered ALU result.
REQ-014 halt  output  1  core stopped on an illegal instruction.

Function
REQ-015 FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-016 FETCH: mem_req=1, mem_we=0, mem_addr=Prx_PC, held stable until the handshake completes; Instruction latched on the handshake cycle; next state DECODE.
REQ-017 DECODE: read rs1/rs2, build immediate; illegal instruction goes to HALT, otherwise EXEC.
REQ-018 Supported instructions: add, sub, and, or (opcode 0110011); addi (0010011, funct3 000); beq (1100011, funct3 000); load/store (0000011/0100011) with funct3 011 when XLEN=64 and 010 when XLEN=32. Any other encoding is illegal.
REQ-019 Immediates are I/S/B-type and sign-extended to XLEN. Arithmetic is modulo 2^XLEN.
REQ-020 EXEC: ALUResult updated. Load/store go to MEM. R-type/addi go to WB. beq sets PC to PC+imm if rs1==rs2, else PC+4, then goes to FETCH.
REQ-021 MEM: mem_req=1, mem_addr=ALUResult[31:0] (no alignment check), mem_we=1 for stores, mem_wdata=rs2. A store completes on handshake, sets PC+4, and goes to FETCH. A load latches mem_rdata on handshake and goes to WB.
REQ-022 WB: write rd, set PC+4, go to FETCH.
REQ-023 Register file is 32 x XLEN. Writes to x0 are discarded and x0 always reads 0.
REQ-024 PC arithmetic is 32-bit and wraps modulo 2^32.
REQ-025 Cycle counts with zero wait (mem_ready=1): beq 3; R-type/addi/store 4; load 5. Each wait cycle adds 1.
REQ-026 mem_req=0 in DECODE, EXEC, WB and HALT. mem_we=0 whenever mem_req=0.
REQ-027 HALT: halt=1, PC and registers frozen, remains until reset.

Reset
REQ-028 Reset=0 at a clock edge gives: state FETCH, Prx_PC=PC_RESET, all registers 0, Instruction 0, ALUResult 0, halt 0.
REQ-029 While Reset=0: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-030 Reset mid-transaction abandons the transaction; mem_ready is ignored until a new request is issued.
REQ-031 First cycle with Reset=1: FETCH request at PC_RESET.

Verification
REQ-032 Hold Reset=0 for 2 cycles, then release -> Prx_PC=0, halt=0, mem_req=0 during reset; mem_req=1, mem_addr=0, mem_we=0 in the first cycle after release.
REQ-033 Zero-wait sequence addi x1,x0,5 (0x00500093) then add x2,x1,x1 (0x00108133) -> ALUResult=10, x2=10, Prx_PC=8 after 8 cycles.
REQ-034 mem_ready held low 3 cycles during a fetch -> mem_req and mem_addr stable throughout; the addi takes 7 cycles.
REQ-035 With x2=10: sd x2,16(x0) (0x00203823) -> mem_we=1, mem_addr=16, mem_wdata=10. Then ld x3,16(x0) (0x01003183) returning 10 -> x3=10; load takes 5 cycles.
REQ-036 beq x0,x0,-8 (0xFE000CE3) at PC 0x18 -> Prx_PC=0x10 after 3 cycles. addi x0,x0,7 -> x0 still reads 0.
REQ-037 Fetch of 0xFFFFFFFF -> halt=1, mem_req=0 indefinitely, Prx_PC unchanged; Reset=0 then clears halt and restarts at PC_RESET.
